cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile.sv | 146 ++++++++++++++
 tb/tb_cp0_regfile.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Ports: clk/reset; MFC0 read (rd_idx/rdata); MTC0 write (wen/widx/wdata);
//   exception commit (exc_*); eret; ext_int lines;
//   outputs epc (with write bypass), int_pending, status_exl.
module cp0_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_idx,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [4:0]  widx,
    input  logic [31:0] wdata,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_in_delay_slot,
    input  logic        eret,
    input  logic [5:0]  ext_int,
    output logic [31:0] epc,
    output logic        int_pending,
    output logic        status_exl
);

    localparam logic [4:0] IDX_BADVADDR = 5'd8;
    localparam logic [4:0] IDX_COUNT    = 5'd9;
    localparam logic [4:0] IDX_COMPARE  = 5'd11;
    localparam logic [4:0] IDX_STATUS   = 5'd12;
    localparam logic [4:0] IDX_CAUSE    = 5'd13;
    localparam logic [4:0] IDX_EPC      = 5'd14;

    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic        ti_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exccode_q;
    logic [5:0]  ext_q;
    logic        tick_q;

    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [7:0]  ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    assign wr_count   = wen && (widx == IDX_COUNT);
    assign wr_compare = wen && (widx == IDX_COMPARE);
    assign wr_status  = wen && (widx == IDX_STATUS);
    assign wr_cause   = wen && (widx == IDX_CAUSE);
    assign wr_epc     = wen && (widx == IDX_EPC);

    // Timer interrupt shares hardware line 5 (IP7).
    assign ip = {ext_q[5] | ti_q, ext_q[4:0], ip_sw_q};

    assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

    always_comb begin
        rdata = 32'h0;
        case (rd_idx)
            IDX_BADVADDR: rdata = badvaddr_q;
            IDX_COUNT:    rdata = count_q;
            IDX_COMPARE:  rdata = compare_q;
            IDX_STATUS:   rdata = status_rd;
            IDX_CAUSE:    rdata = cause_rd;
            IDX_EPC:      rdata = epc_q;
            default:      rdata = 32'h0;
        endcase
    end

    // An exception owns EPC this cycle, so the MTC0 value is not forwarded.
    assign epc         = (wr_epc && !exc_valid) ? wdata : epc_q;
    assign int_pending = ie_q && !exl_q && |(ip & im_q);
    assign status_exl  = exl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            epc_q      <= 32'h0;
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'b0;
            exccode_q  <= 5'h0;
            ext_q      <= 6'h0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            ext_q  <= ext_int;

            if (wr_count)
                count_q <= wdata;
            else if (tick_q)
                count_q <= count_q + 32'd1;

            if (wr_compare)
                compare_q <= wdata;

            // Compare write beats a simultaneous match.
            if (wr_compare)
                ti_q <= 1'b0;
            else if (count_q == compare_q)
                ti_q <= 1'b1;

            if (wr_status) begin
                im_q <= wdata[15:8];
                ie_q <= wdata[0];
            end

            if (wr_cause)
                ip_sw_q <= wdata[9:8];

            if (exc_valid) begin
                exccode_q <= exc_code;
                exl_q     <= 1'b1;
                if (!exl_q) begin
                    epc_q <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    bd_q  <= exc_in_delay_slot;
                end
                if (exc_code == 5'd4 || exc_code == 5'd5)
                    badvaddr_q <= exc_badvaddr;
            end else begin
                if (eret)
                    exl_q <= 1'b0;
                else if (wr_status)
                    exl_q <= wdata[1];
                if (wr_epc)
                    epc_q <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile.
// Drives one scenario per task and compares against hand-computed values.
module tb_cp0_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_idx;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        exc_in_delay_slot;
    logic        eret;
    logic [5:0]  ext_int;
    logic [31:0] epc;
    logic        int_pending;
    logic        status_exl;

    int errors = 0;
    int checks = 0;

    cp0_regfile dut (
        .clk(clk),
        .reset(reset),
        .rd_idx(rd_idx),
        .rdata(rdata),
        .wen(wen),
        .widx(widx),
        .wdata(wdata),
        .exc_valid(exc_valid),
        .exc_code(exc_code),
        .exc_pc(exc_pc),
        .exc_badvaddr(exc_badvaddr),
        .exc_in_delay_slot(exc_in_delay_slot),
        .eret(eret),
        .ext_int(ext_int),
        .epc(epc),
        .int_pending(int_pending),
        .status_exl(status_exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] i, input logic [31:0] d);
        wen = 1'b1;
        widx = i;
        wdata = d;
        step();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] i, output logic [31:0] v);
        rd_idx = i;
        #1;
        v = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #2;
        rd(5'd12, v);
        checks++;
        if (v !== 32'h00400000) begin
            errors++;
            $display("FAIL rst_status got %h exp 00400000", v);
        end
        checks++;
        if ({int_pending, status_exl} !== 2'b00 || epc !== 32'h0) begin
            errors++;
            $display("FAIL rst_outs got %b%b %h exp 00 0", int_pending, status_exl, epc);
        end
        @(negedge clk);
        reset = 1'b0;
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_cause got %h exp 0", v);
        end
        rd(5'd9, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_count got %h exp 0", v);
        end
        repeat (10) step();
        rd(5'd9, v);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL count_10clk got %h exp 5", v);
        end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        mtc0(5'd11, 32'h10);
        mtc0(5'd9, 32'h0E);
        repeat (8) step();
        rd(5'd13, v);
        checks++;
        if (v[30] !== 1'b1 || v[15] !== 1'b1) begin
            errors++;
            $display("FAIL timer_ti got %h exp bits30,15 set", v);
        end
        mtc0(5'd12, 32'h00008001);
        rd(5'd12, v);
        checks++;
        if (v !== 32'h00408001 || int_pending !== 1'b1) begin
            errors++;
            $display("FAIL timer_pend got %h %b exp 00408001 1", v, int_pending);
        end
        mtc0(5'd11, 32'h100);
        rd(5'd13, v);
        checks++;
        if (v[30] !== 1'b0 || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL timer_clr got %h %b exp TI0 0", v, int_pending);
        end
    endtask

    task automatic test_ext_int();
        logic [31:0] v;
        mtc0(5'd12, 32'h00000401);
        ext_int = 6'b000001;
        step();
        rd(5'd13, v);
        checks++;
        if (v !== 32'h00000400 || int_pending !== 1'b1) begin
            errors++;
            $display("FAIL ext_pend got %h %b exp 00000400 1", v, int_pending);
        end
        ext_int = 6'b0;
        step();
        checks++;
        if (int_pending !== 1'b0) begin
            errors++;
            $display("FAIL ext_clr got %b exp 0", int_pending);
        end
        mtc0(5'd13, 32'hFFFFFFFF);
        rd(5'd13, v);
        checks++;
        if (v !== 32'h00000300) begin
            errors++;
            $display("FAIL cause_sw got %h exp 00000300", v);
        end
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_exception();
        logic [31:0] v;
        exc_valid = 1'b1;
        exc_code = 5'd4;
        exc_pc = 32'hBFC00104;
        exc_in_delay_slot = 1'b1;
        exc_badvaddr = 32'h3;
        step();
        exc_valid = 1'b0;
        rd(5'd14, v);
        checks++;
        if (v !== 32'hBFC00100 || epc !== 32'hBFC00100) begin
            errors++;
            $display("FAIL exc1_epc got %h %h exp BFC00100", v, epc);
        end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h80000010) begin
            errors++;
            $display("FAIL exc1_cause got %h exp 80000010", v);
        end
        rd(5'd8, v);
        checks++;
        if (v !== 32'h3 || status_exl !== 1'b1) begin
            errors++;
            $display("FAIL exc1_bva got %h %b exp 3 1", v, status_exl);
        end
        exc_valid = 1'b1;
        exc_code = 5'd8;
        exc_pc = 32'h80000000;
        exc_in_delay_slot = 1'b0;
        exc_badvaddr = 32'h1234;
        step();
        exc_valid = 1'b0;
        rd(5'd14, v);
        checks++;
        if (v !== 32'hBFC00100) begin
            errors++;
            $display("FAIL exc2_epc got %h exp BFC00100", v);
        end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h80000020) begin
            errors++;
            $display("FAIL exc2_cause got %h exp 80000020", v);
        end
        rd(5'd8, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL exc2_bva got %h exp 3", v);
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        eret = 1'b1;
        mtc0(5'd12, 32'h3);
        eret = 1'b0;
        rd(5'd12, v);
        checks++;
        if (v !== 32'h00400001 || status_exl !== 1'b0) begin
            errors++;
            $display("FAIL pri_eret got %h %b exp 00400001 0", v, status_exl);
        end
        eret = 1'b1;
        exc_valid = 1'b1;
        exc_code = 5'd0;
        exc_pc = 32'h80000100;
        exc_in_delay_slot = 1'b0;
        mtc0(5'd12, 32'h3);
        eret = 1'b0;
        exc_valid = 1'b0;
        rd(5'd12, v);
        checks++;
        if (v !== 32'h00400003 || epc !== 32'h80000100) begin
            errors++;
            $display("FAIL pri_exc got %h %h exp 00400003 80000100", v, epc);
        end
        rd(5'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL pri_cause got %h exp 0", v);
        end
        exc_valid = 1'b1;
        exc_pc = 32'h80000200;
        wen = 1'b1;
        widx = 5'd14;
        wdata = 32'hDEAD0000;
        #1;
        checks++;
        if (epc !== 32'h80000100) begin
            errors++;
            $display("FAIL pri_nobyp got %h exp 80000100", epc);
        end
        step();
        wen = 1'b0;
        exc_valid = 1'b0;
        rd(5'd14, v);
        checks++;
        if (v !== 32'h80000100) begin
            errors++;
            $display("FAIL pri_epcdrop got %h exp 80000100", v);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    task automatic test_epc_bypass();
        logic [31:0] v;
        wen = 1'b1;
        widx = 5'd14;
        wdata = 32'h80001234;
        rd(5'd14, v);
        checks++;
        if (epc !== 32'h80001234 || v !== 32'h80000100) begin
            errors++;
            $display("FAIL byp_same got %h %h exp 80001234 80000100", epc, v);
        end
        step();
        wen = 1'b0;
        rd(5'd14, v);
        checks++;
        if (epc !== 32'h80001234 || v !== 32'h80001234) begin
            errors++;
            $display("FAIL byp_next got %h %h exp 80001234", epc, v);
        end
    endtask

    task automatic test_unimpl();
        logic [31:0] v;
        mtc0(5'd5, 32'hFFFFFFFF);
        rd(5'd5, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL unimpl5 got %h exp 0", v);
        end
        mtc0(5'd8, 32'hFFFFFFFF);
        rd(5'd8, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL bva_ro got %h exp 3", v);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] v;
        mtc0(5'd9, 32'hFFFFFFFF);
        step();
        step();
        rd(5'd9, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL count_wrap got %h exp 0", v);
        end
        mtc0(5'd12, 32'h00008001);
        exc_valid = 1'b1;
        exc_code = 5'd4;
        exc_pc = 32'h80000400;
        exc_badvaddr = 32'h77;
        #2;
        reset = 1'b1;
        rd(5'd12, v);
        checks++;
        if (v !== 32'h00400000 || epc !== 32'h0) begin
            errors++;
            $display("FAIL async_rst got %h %h exp 00400000 0", v, epc);
        end
        checks++;
        if ({int_pending, status_exl} !== 2'b00) begin
            errors++;
            $display("FAIL async_outs got %b%b exp 00", int_pending, status_exl);
        end
        @(negedge clk);
        exc_valid = 1'b0;
        reset = 1'b0;
        rd(5'd8, v);
        checks++;
        if (v !== 32'h0 || status_exl !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got %h %b exp 0 0", v, status_exl);
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_idx = 5'd0;
        wen = 1'b0;
        widx = 5'd0;
        wdata = 32'h0;
        exc_valid = 1'b0;
        exc_code = 5'd0;
        exc_pc = 32'h0;
        exc_badvaddr = 32'h0;
        exc_in_delay_slot = 1'b0;
        eret = 1'b0;
        ext_int = 6'h0;
        test_reset();
        test_timer();
        test_ext_int();
        test_exception();
        test_priority();
        test_epc_bypass();
        test_unimpl();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
